// File: rtl/alu_result_fifo.sv
// Capture FIFO behind the 8-bit ALU: buffers each result with its flags (first-word fall-through),
// raises an early hold to upstream, counts overflow drops and keeps sticky carry/overflow flags.
module alu_result_fifo #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [7:0]               in_result,
  input  logic                     in_carry,
  input  logic                     in_zero,
  input  logic                     in_overflow,
  output logic                     in_hold,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [10:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  input  logic                     flush,
  input  logic                     clr_status,
  output logic [7:0]               drop_count,
  output logic                     sticky_carry,
  output logic                     sticky_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthLevel = CW'(DEPTH);
  localparam logic [CW-1:0] HoldLevel  = CW'(DEPTH - HOLD_MARGIN);

  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    drop_count_q;
  logic          sticky_carry_q, sticky_ovf_q;

  logic pop_req, push, pop, drop;
  logic [10:0] in_entry;

  assign in_entry = {in_overflow, in_zero, in_carry, in_result};

  assign empty     = (count_q == '0);
  assign full      = (count_q == DepthLevel);
  assign out_valid = ~empty;
  assign in_hold   = (count_q >= HoldLevel);
  assign count     = count_q;

  // A drop is judged against the consumer's handshake alone; flush only cancels push/pop.
  assign pop_req = out_valid & out_ready;
  assign pop     = pop_req & ~flush;
  assign push    = in_valid & (~full | pop_req) & ~flush;
  assign drop    = in_valid & full & ~pop_req;

  assign out_data     = empty ? 11'h000 : mem_q[rd_ptr_q];
  assign drop_count   = drop_count_q;
  assign sticky_carry = sticky_carry_q;
  assign sticky_ovf   = sticky_ovf_q;

  // Storage is not reset; out_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Status: a new event in the same cycle as clr_status takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_q   <= '0;
      sticky_carry_q <= 1'b0;
      sticky_ovf_q   <= 1'b0;
    end else begin
      if (clr_status) begin
        drop_count_q   <= drop ? 8'd1 : 8'd0;
        sticky_carry_q <= push & in_carry;
        sticky_ovf_q   <= push & in_overflow;
      end else begin
        if (drop && drop_count_q != 8'hFF) begin
          drop_count_q <= drop_count_q + 8'd1;
        end
        sticky_carry_q <= sticky_carry_q | (push & in_carry);
        sticky_ovf_q   <= sticky_ovf_q | (push & in_overflow);
      end
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: hand-computed vectors for push, drop, FWFT order, wrap,
// saturation, clr_status priority, flush and asynchronous reset.
module tb_alu_result_fifo;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_result;
  logic        in_carry, in_zero, in_overflow;
  logic        in_hold;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;
  logic [2:0]  count;
  logic        full, empty;
  logic        flush, clr_status;
  logic [7:0]  drop_count;
  logic        sticky_carry, sticky_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  alu_result_fifo #(
    .DEPTH      (DEPTH),
    .HOLD_MARGIN(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_result   (in_result),
    .in_carry    (in_carry),
    .in_zero     (in_zero),
    .in_overflow (in_overflow),
    .in_hold     (in_hold),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .flush       (flush),
    .clr_status  (clr_status),
    .drop_count  (drop_count),
    .sticky_carry(sticky_carry),
    .sticky_ovf  (sticky_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] r, input logic c, input logic z, input logic o);
    in_valid    = 1'b1;
    in_result   = r;
    in_carry    = c;
    in_zero     = z;
    in_overflow = o;
    step();
    in_valid    = 1'b0;
    in_carry    = 1'b0;
    in_zero     = 1'b0;
    in_overflow = 1'b0;
  endtask

  int exp_q[5];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_carry = 1'b0; in_zero = 1'b0;
    in_overflow = 1'b0; out_ready = 1'b0; flush = 1'b0; clr_status = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_empty",     32'(empty), 1);
    check("rst_full",      32'(full), 0);
    check("rst_hold",      32'(in_hold), 0);
    check("rst_count",     32'(count), 0);
    check("rst_out_data",  32'(out_data), 0);
    check("rst_drop",      32'(drop_count), 0);
    check("rst_sticky",    32'({sticky_carry, sticky_ovf}), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single push, latency one.
    push(8'h80, 1'b1, 1'b0, 1'b1);
    check("t1_out_valid", 32'(out_valid), 1);
    check("t1_out_data",  32'(out_data), 'h580);
    check("t1_count",     32'(count), 1);
    check("t1_sticky_c",  32'(sticky_carry), 1);
    check("t1_sticky_o",  32'(sticky_ovf), 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("t1_empty", 32'(empty), 1);
    check("t1_data0", 32'(out_data), 0);
    clr_status = 1'b1; step(); clr_status = 1'b0;
    check("t1_clr_sticky", 32'({sticky_carry, sticky_ovf}), 0);

    // Fill to full with hold reporting, then one drop.
    push(8'h01, 1'b0, 1'b0, 1'b0);
    check("t2_hold_c1", 32'(in_hold), 0);
    push(8'h02, 1'b0, 1'b0, 1'b0);
    check("t2_hold_c2", 32'(in_hold), 1);
    push(8'h03, 1'b0, 1'b0, 1'b0);
    push(8'h04, 1'b0, 1'b0, 1'b0);
    check("t2_full",  32'(full), 1);
    check("t2_count", 32'(count), 4);
    push(8'h05, 1'b0, 1'b0, 1'b0);
    check("t2_drop",  32'(drop_count), 1);
    check("t2_count_after_drop", 32'(count), 4);
    check("t2_head",  32'(out_data), 'h001);

    // Simultaneous push and pop while full.
    in_valid = 1'b1; in_result = 8'h77; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t3_count", 32'(count), 4);
    check("t3_drop",  32'(drop_count), 1);
    check("t3_head",  32'(out_data), 'h002);

    exp_q = '{'h002, 'h003, 'h004, 'h077, 0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_drain%0d", i), 32'(out_data), 32'(exp_q[i]));
      step();
    end
    out_ready = 1'b0;
    check("t3_empty", 32'(empty), 1);

    // Streaming across pointer wrap.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_result = 8'(8'h10 + i);
      step();
      check($sformatf("t4_data%0d", i), 32'(out_data), 32'('h10 + i));
      check($sformatf("t4_count%0d", i), 32'(count), 1);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("t4_count_end", 32'(count), 0);
    check("t4_drop", 32'(drop_count), 1);

    // Saturating drops; dropped carry/overflow must not set sticky flags.
    for (int i = 0; i < 4; i++) push(8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; in_result = 8'hEE; in_carry = 1'b1; in_overflow = 1'b1;
    for (int i = 0; i < 300; i++) step();
    check("t5_drop_sat", 32'(drop_count), 255);
    check("t5_sticky_drop", 32'({sticky_carry, sticky_ovf}), 0);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0; in_valid = 1'b0; in_carry = 1'b0; in_overflow = 1'b0;
    check("t5_clr_vs_drop", 32'(drop_count), 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("t5_count3", 32'(count), 3);
    flush = 1'b1; step(); flush = 1'b0;
    check("t5_flush_empty", 32'(empty), 1);
    check("t5_flush_count", 32'(count), 0);
    check("t5_flush_drop",  32'(drop_count), 1);

    // Asynchronous reset mid-stream.
    push(8'h31, 1'b1, 1'b0, 1'b1);
    push(8'h32, 1'b0, 1'b0, 1'b0);
    push(8'h33, 1'b0, 1'b0, 1'b0);
    check("t6_pre_count", 32'(count), 3);
    check("t6_pre_sticky", 32'({sticky_carry, sticky_ovf}), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", 32'(out_valid), 0);
    check("t6_count",     32'(count), 0);
    check("t6_sticky",    32'({sticky_carry, sticky_ovf}), 0);
    check("t6_drop",      32'(drop_count), 0);
    check("t6_out_data",  32'(out_data), 0);
    step();
    rst_n = 1'b1;
    step();
    check("t6_still_empty", 32'(empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
